// File: rtl/conv_pkg.sv
// Shared types for the convolution layer wrapper.
package conv_pkg;

  typedef enum logic {
    MUX_CONVOLUTION = 1'b0,
    MUX_POOLING     = 1'b1
  } arbiter_mode_t;

endpackage

// File: rtl/conv_phase_scheduler.sv
// Phase sequencer for the convolution layer: PAUSE / CONVOLUTION / DRAIN / POOLING.
// Outputs decode from registered state; pool_enable is gated combinationally by output backpressure.
module conv_phase_scheduler
  import conv_pkg::*;
#(
  parameter int POOL_PERIOD    = 1,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TS_COUNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      timestep_event,
  input  logic                      input_fifo_empty,
  input  logic                      conv_active,
  input  logic                      pool_active,
  input  logic                      pool_done,
  input  logic                      output_fifo_full_next,
  output logic                      capture_enable,
  output arbiter_mode_t             arbiter_mode,
  output logic                      pool_start,
  output logic                      pool_enable,
  output logic [TS_COUNT_WIDTH-1:0] timestep_count,
  output logic                      idle
);

  localparam int PW = $clog2(POOL_PERIOD + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    PAUSE       = 2'd0,
    CONVOLUTION = 2'd1,
    DRAIN       = 2'd2,
    POOLING     = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             pending_q, pending_d;
  logic [DW-1:0]             drain_cnt_q, drain_cnt_d;
  logic [TS_COUNT_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
  logic                      pool_start_q, pool_start_d;
  logic [PW-1:0]             pending_inc;

  assign pending_inc = pending_q + PW'(1);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    drain_cnt_d  = drain_cnt_q;
    ts_cnt_d     = ts_cnt_q;
    pool_start_d = 1'b0;
    case (state_q)
      PAUSE: begin
        if (enable) state_d = CONVOLUTION;
      end
      CONVOLUTION: begin
        if (timestep_event) begin
          ts_cnt_d  = ts_cnt_q + TS_COUNT_WIDTH'(1);
          pending_d = pending_inc;
        end
        // A completed pooling period wins over a simultaneous run-request drop.
        if (timestep_event && (pending_inc == PW'(POOL_PERIOD))) begin
          state_d = DRAIN;
        end else if (!enable) begin
          state_d = PAUSE;
        end
      end
      DRAIN: begin
        if (conv_active) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d      = POOLING;
          drain_cnt_d  = '0;
          pending_d    = '0;
          pool_start_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      POOLING: begin
        if (pool_done) state_d = enable ? CONVOLUTION : PAUSE;
      end
      default: state_d = PAUSE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PAUSE;
      pending_q    <= '0;
      drain_cnt_q  <= '0;
      ts_cnt_q     <= '0;
      pool_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      drain_cnt_q  <= drain_cnt_d;
      ts_cnt_q     <= ts_cnt_d;
      pool_start_q <= pool_start_d;
    end
  end

  assign capture_enable = (state_q == CONVOLUTION);
  assign arbiter_mode   = (state_q == POOLING) ? MUX_POOLING : MUX_CONVOLUTION;
  assign pool_start     = pool_start_q;
  assign pool_enable    = (state_q == POOLING) && !output_fifo_full_next;
  assign timestep_count = ts_cnt_q;

  always_comb begin
    idle = 1'b0;
    case (state_q)
      PAUSE:       idle = 1'b1;
      CONVOLUTION: idle = input_fifo_empty && !conv_active;
      default:     idle = 1'b0;
    endcase
  end

  // Timestep markers can only arrive while capture is enabled.
  a_ts_in_conv: assert property (@(posedge clk) disable iff (!rst_n)
    timestep_event |-> (state_q == CONVOLUTION));

  a_pool_active_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != POOLING) |-> !pool_active);

  a_arb_stable_conv: assert property (@(posedge clk) disable iff (!rst_n)
    conv_active |=> $stable(arbiter_mode));

endmodule

// File: tb/tb_conv_phase_scheduler.sv
// Directed bench for conv_phase_scheduler: instance A (POOL_PERIOD=1) and instance B (POOL_PERIOD=3).
module tb_conv_phase_scheduler;
  import conv_pkg::*;

  logic clk, rst_n;
  logic en_a, en_b, ts_a, ts_b;
  logic fifo_empty, conv_act, pool_act, pool_done, full;

  logic          cap_a, start_a, pen_a, idle_a;
  arbiter_mode_t arb_a;
  logic [15:0]   tsc_a;
  logic          cap_b, start_b, pen_b, idle_b;
  arbiter_mode_t arb_b;
  logic [15:0]   tsc_b;

  int n_chk  = 0;
  int n_fail = 0;

  conv_phase_scheduler #(.POOL_PERIOD(1), .DRAIN_CYCLES(4), .TS_COUNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .timestep_event(ts_a),
    .input_fifo_empty(fifo_empty), .conv_active(conv_act), .pool_active(pool_act),
    .pool_done(pool_done), .output_fifo_full_next(full),
    .capture_enable(cap_a), .arbiter_mode(arb_a), .pool_start(start_a),
    .pool_enable(pen_a), .timestep_count(tsc_a), .idle(idle_a)
  );

  conv_phase_scheduler #(.POOL_PERIOD(3), .DRAIN_CYCLES(4), .TS_COUNT_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .timestep_event(ts_b),
    .input_fifo_empty(fifo_empty), .conv_active(conv_act), .pool_active(pool_act),
    .pool_done(pool_done), .output_fifo_full_next(full),
    .capture_enable(cap_b), .arbiter_mode(arb_b), .pool_start(start_b),
    .pool_enable(pen_b), .timestep_count(tsc_b), .idle(idle_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; ts_a = 1'b0; ts_b = 1'b0;
    fifo_empty = 1'b1; conv_act = 1'b0; pool_act = 1'b0; pool_done = 1'b0; full = 1'b0;
    #12;
    chk("rst_cap", cap_a, 0);
    chk("rst_arb", arb_a, MUX_CONVOLUTION);
    chk("rst_start", start_a, 0);
    chk("rst_pen", pen_a, 0);
    chk("rst_tsc", tsc_a, 0);
    chk("rst_idle", idle_a, 1);
    rst_n = 1'b1;
    tick();

    // Basic flow, POOL_PERIOD=1
    en_a = 1'b1; conv_act = 1'b1;
    tick();
    chk("conv_cap", cap_a, 1);
    chk("conv_idle_busy", idle_a, 0);
    conv_act = 1'b0; #1;
    chk("conv_idle_quiet", idle_a, 1);
    conv_act = 1'b1;
    tick(); tick();
    ts_a = 1'b1; tick(); ts_a = 1'b0;
    chk("ev_cap_low", cap_a, 0);
    chk("ev_tsc1", tsc_a, 1);
    chk("drain_idle", idle_a, 0);
    tick();
    conv_act = 1'b0;
    tick(); tick(); tick();
    chk("drain3_start", start_a, 0);
    chk("drain3_arb", arb_a, MUX_CONVOLUTION);
    tick();
    chk("pool_start", start_a, 1);
    chk("pool_arb", arb_a, MUX_POOLING);
    chk("pool_pen", pen_a, 1);

    // Backpressure for 5 cycles, then pool_done while still almost full
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_pen", pen_a, 0);
      tick();
      if (i == 0) chk("start_one_shot", start_a, 0);
    end
    full = 1'b0; #1;
    chk("bp_release_pen", pen_a, 1);
    pool_done = 1'b1; full = 1'b1; #1;
    chk("done_full_pen", pen_a, 0);
    tick(); pool_done = 1'b0; full = 1'b0;
    chk("done_conv_cap", cap_a, 1);
    chk("done_arb", arb_a, MUX_CONVOLUTION);
    chk("done_pen", pen_a, 0);

    // enable dropped during DRAIN does not abort; pool_done then goes to PAUSE
    ts_a = 1'b1; tick(); ts_a = 1'b0;
    chk("ev_tsc2", tsc_a, 2);
    en_a = 1'b0;
    tick(); tick(); tick();
    chk("drain_noabort_arb", arb_a, MUX_CONVOLUTION);
    chk("drain_noabort_cap", cap_a, 0);
    tick();
    chk("noabort_start", start_a, 1);
    chk("noabort_arb", arb_a, MUX_POOLING);
    tick();
    pool_done = 1'b1; tick(); pool_done = 1'b0;
    chk("pause_cap", cap_a, 0);
    chk("pause_idle", idle_a, 1);
    chk("pause_arb", arb_a, MUX_CONVOLUTION);
    tick();
    chk("pause_hold", cap_a, 0);
    en_a = 1'b1; tick();
    chk("resume_cap", cap_a, 1);
    en_a = 1'b0; tick();
    chk("conv_to_pause", cap_a, 0);
    en_a = 1'b1; tick();
    chk("conv_again", cap_a, 1);
    pool_done = 1'b1; tick(); pool_done = 1'b0;
    chk("stray_done_arb", arb_a, MUX_CONVOLUTION);
    chk("stray_done_cap", cap_a, 1);

    // Asynchronous reset in the middle of DRAIN
    conv_act = 1'b1;
    ts_a = 1'b1; tick(); ts_a = 1'b0;
    chk("ev_tsc3", tsc_a, 3);
    tick();
    rst_n = 1'b0; #1;
    chk("arst_tsc", tsc_a, 0);
    chk("arst_idle", idle_a, 1);
    chk("arst_cap", cap_a, 0);
    chk("arst_arb", arb_a, MUX_CONVOLUTION);
    chk("arst_start", start_a, 0);
    chk("arst_pen", pen_a, 0);
    tick();
    chk("arst_hold_cap", cap_a, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cap", cap_a, 1);

    // conv_active bouncing during DRAIN keeps restarting the drain window
    ts_a = 1'b1; tick(); ts_a = 1'b0;
    chk("ev_tsc_after_rst", tsc_a, 1);
    for (int i = 0; i < 12; i++) begin
      conv_act = (i % 3 == 0);
      tick();
      chk("bounce_arb", arb_a, MUX_CONVOLUTION);
      chk("bounce_start", start_a, 0);
    end
    conv_act = 1'b0;
    tick();
    chk("bounce_tail_start", start_a, 0);
    tick();
    chk("bounce_pool_start", start_a, 1);
    chk("bounce_pool_arb", arb_a, MUX_POOLING);
    en_a = 1'b0;
    pool_done = 1'b1; tick(); pool_done = 1'b0;
    chk("bounce_pause_cap", cap_a, 0);
    chk("bounce_pause_idle", idle_a, 1);

    // POOL_PERIOD=3 on instance B
    en_b = 1'b1;
    tick();
    chk("b_conv_cap", cap_b, 1);
    ts_b = 1'b1; tick(); ts_b = 1'b0;
    chk("b_tsc1", tsc_b, 1);
    chk("b_cap1", cap_b, 1);
    tick();
    ts_b = 1'b1; tick(); ts_b = 1'b0;
    chk("b_tsc2", tsc_b, 2);
    chk("b_cap2", cap_b, 1);
    chk("b_start2", start_b, 0);
    tick();
    ts_b = 1'b1; tick(); ts_b = 1'b0;
    chk("b_tsc3", tsc_b, 3);
    chk("b_cap3", cap_b, 0);
    tick(); tick(); tick();
    chk("b_drain_start", start_b, 0);
    tick();
    chk("b_pool_start", start_b, 1);
    chk("b_pool_arb", arb_b, MUX_POOLING);
    chk("a_untouched_idle", idle_a, 1);
    en_b = 1'b0;
    pool_done = 1'b1; tick(); pool_done = 1'b0;
    chk("b_pause_cap", cap_b, 0);
    chk("b_pause_idle", idle_b, 1);
    chk("b_pause_arb", arb_b, MUX_CONVOLUTION);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
